// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and encodings for the CPU-to-data-memory access controller.
package mem_access_ctrl_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_RESP
   } state_t;

   localparam logic [1:0] SZ_BYTE    = 2'b00;
   localparam logic [1:0] SZ_HALF    = 2'b01;
   localparam logic [1:0] SZ_WORD    = 2'b10;
   localparam logic [1:0] SZ_ILLEGAL = 2'b11;

endpackage

// File: rtl/mem_access_ctrl_lane_align.sv
// Lane extraction for loads and lane merge for sub-word stores (32-bit words).
import mem_access_ctrl_pkg::*;

module mem_lane_align (
   input  logic [31:0] mem_word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merge_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v     = mem_word[{lane, 3'b000} +: 8];
      half_v     = lane[1] ? mem_word[31:16] : mem_word[15:0];
      load_data  = mem_word;
      merge_data = wdata;
      case (size)
         SZ_BYTE: begin
            load_data  = {{24{sign_ext & byte_v[7]}}, byte_v};
            merge_data = mem_word;
            merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data  = {{16{sign_ext & half_v[15]}}, half_v};
            merge_data = mem_word;
            if (lane[1]) merge_data[31:16] = wdata[15:0];
            else         merge_data[15:0]  = wdata[15:0];
         end
         default: begin
            load_data  = mem_word;
            merge_data = wdata;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding CPU load/store controller for a word-wide data memory,
// with sub-word stores done as read-modify-write. Only DATA_WIDTH=32 is supported.
import mem_access_ctrl_pkg::*;

module mem_access_ctrl #(
   parameter int unsigned ADDRESS_WIDTH = 16,
   parameter int unsigned DATA_WIDTH    = 32
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [1:0]               req_size,
   input  logic                     req_signed,
   input  logic [31:0]              req_addr,
   input  logic [31:0]              req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [31:0]              rsp_rdata,
   output logic                     rsp_err,
   output logic [ADDRESS_WIDTH-1:0] Address,
   output logic [DATA_WIDTH-1:0]    WriteData,
   output logic                     MemWrite,
   input  logic [DATA_WIDTH-1:0]    MemData
);

   state_t      state;
   logic        wr_q;
   logic        sgn_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic [31:0] wdata_q;
   logic        mem_write_q;
   logic        req_err;
   logic [31:0] hi_bits;
   logic [31:0] load_data;
   logic [31:0] merge_data;

   mem_lane_align u_lane (
      .mem_word   (32'(MemData)),
      .lane       (lane_q),
      .size       (size_q),
      .sign_ext   (sgn_q),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .merge_data (merge_data)
   );

   always_comb begin
      hi_bits = req_addr >> (ADDRESS_WIDTH + 2);
      req_err = 1'b0;
      case (req_size)
         SZ_BYTE: req_err = 1'b0;
         SZ_HALF: req_err = req_addr[0];
         SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
         default: req_err = 1'b1;
      endcase
      if (hi_bits != '0) req_err = 1'b1;
   end

   // Reset takes effect at the same edge the memory samples, so the strobe is gated by Rst directly.
   assign MemWrite = mem_write_q & ~Rst;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state       <= ST_IDLE;
         req_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_rdata   <= '0;
         mem_write_q <= 1'b0;
         Address     <= '0;
         WriteData   <= '0;
         wr_q        <= 1'b0;
         sgn_q       <= 1'b0;
         size_q      <= '0;
         lane_q      <= '0;
         wdata_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  wr_q      <= req_write;
                  sgn_q     <= req_signed;
                  size_q    <= req_size;
                  lane_q    <= req_addr[1:0];
                  wdata_q   <= req_wdata;
                  req_ready <= 1'b0;
                  rsp_rdata <= '0;
                  if (req_err) begin
                     rsp_err   <= 1'b1;
                     rsp_valid <= 1'b1;
                     state     <= ST_RESP;
                  end else begin
                     rsp_err <= 1'b0;
                     Address <= req_addr[ADDRESS_WIDTH+1:2];
                     if (req_write && (req_size == SZ_WORD)) begin
                        WriteData   <= DATA_WIDTH'(req_wdata);
                        mem_write_q <= 1'b1;
                        state       <= ST_WRITE;
                     end else begin
                        state <= ST_READ;
                     end
                  end
               end
            end
            ST_READ: begin
               if (wr_q) begin
                  WriteData   <= DATA_WIDTH'(merge_data);
                  mem_write_q <= 1'b1;
                  state       <= ST_WRITE;
               end else begin
                  rsp_rdata <= load_data;
                  rsp_valid <= 1'b1;
                  state     <= ST_RESP;
               end
            end
            ST_WRITE: begin
               mem_write_q <= 1'b0;
               rsp_valid   <= 1'b1;
               state       <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: driver pushes model-predicted responses, monitor pops and compares.
import mem_access_ctrl_pkg::*;

module tb_mem_access_ctrl;

   localparam int unsigned AW = 16;

   logic          Clk = 1'b0;
   logic          Rst = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_write = 1'b0;
   logic [1:0]    req_size = 2'b00;
   logic          req_signed = 1'b0;
   logic [31:0]   req_addr = '0;
   logic [31:0]   req_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] Address;
   logic [31:0]   WriteData;
   logic          MemWrite;
   logic [31:0]   MemData;

   mem_access_ctrl #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(32)) dut (
      .Clk(Clk), .Rst(Rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .Address(Address),
      .WriteData(WriteData), .MemWrite(MemWrite), .MemData(MemData)
   );

   always #5 Clk = ~Clk;

   logic [31:0] mem     [0:65535];
   logic [31:0] ref_mem [0:65535];

   assign MemData = mem[Address];
   always @(posedge Clk) if (MemWrite === 1'b1) mem[Address] <= WriteData;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          nwr;
      logic [15:0] widx;
      logic [31:0] word;
      int          acc;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   failures = 0;
   int   hold_cnt = 0;
   bit   in_resp = 1'b0;

   localparam logic [83:0] RST_VEC = {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 16'h0, 32'h0};

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic finish_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   endtask

   // Reference: byte-addressed semantics over an array of words.
   task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, output exp_t e);
      int unsigned nb;
      int unsigned sh;
      logic [31:0] mask;
      logic [31:0] val;
      e.widx  = addr[17:2];
      e.err   = 1'b0;
      e.rdata = '0;
      e.nwr   = 0;
      e.acc   = 0;
      case (sz)
         2'd0:    nb = 1;
         2'd1:    nb = 2;
         2'd2:    nb = 4;
         default: nb = 0;
      endcase
      if (nb == 0 || (addr % nb) != 0 || addr >= (32'd1 << (AW + 2))) e.err = 1'b1;
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 1);
      sh   = 8 * addr[1:0];
      if (e.err) begin
         e.lat = 1;
      end else if (wr) begin
         ref_mem[e.widx] = (ref_mem[e.widx] & ~(mask << sh)) | ((wd & mask) << sh);
         e.nwr = 1;
         e.lat = (nb == 4) ? 2 : 3;
      end else begin
         val = (ref_mem[e.widx] >> sh) & mask;
         if (sg && nb < 4 && val[8 * nb - 1]) val = val | ~mask;
         e.rdata = val;
         e.lat   = 2;
      end
      e.word = ref_mem[e.widx];
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge Clk);
      while (req_ready !== 1'b1) begin
         n++;
         if (n > 300) begin
            checks++;
            failures++;
            $display("FAIL wait_req_ready: got %b expected 1 within 300 cycles", req_ready);
            finish_run();
         end
         @(negedge Clk);
      end
   endtask

   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input bit expect_rsp);
      exp_t e;
      wait_idle();
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wd;
      req_valid  = 1'b1;
      @(posedge Clk);
      #1;
      req_valid = 1'b0;
      if (expect_rsp) begin
         model(wr, sz, sg, addr, wd, e);
         e.acc = cyc;
         expq.push_back(e);
      end
   endtask

   exp_t        cur;
   int          wr_cnt = 0;
   logic [15:0] wr_addr = '0;

   always @(negedge Clk) begin
      if (Rst) begin
         in_resp = 1'b0;
         wr_cnt  = 0;
      end else begin
         if (MemWrite === 1'b1) begin
            wr_cnt++;
            wr_addr = Address;
         end
         if (rsp_valid === 1'b1) begin
            if (!in_resp) begin
               if (expq.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response pending");
               end else begin
                  cur     = expq.pop_front();
                  in_resp = 1'b1;
                  chk("latency", 128'(cyc - cur.acc + 1), 128'(cur.lat));
                  chk("rsp_err", rsp_err, cur.err);
                  chk("rsp_rdata", rsp_rdata, cur.rdata);
                  chk("write_pulses", 128'(wr_cnt), 128'(cur.nwr));
                  if (cur.nwr == 1) chk("write_addr", wr_addr, cur.widx);
                  chk("mem_word", mem[cur.widx], cur.word);
                  wr_cnt = 0;
               end
            end else begin
               chk("rsp_stable", {rsp_err, rsp_rdata}, {cur.err, cur.rdata});
            end
            chk("req_ready_busy", req_ready, 1'b0);
            if (hold_cnt > 0) begin
               rsp_ready = 1'b0;
               hold_cnt--;
            end else begin
               rsp_ready = ($urandom_range(0, 3) != 0);
            end
            if (rsp_ready) in_resp = 1'b0;
         end else begin
            rsp_ready = $urandom_range(0, 1) != 0;
         end
      end
   end

   initial begin
      logic [31:0] v;
      logic [1:0]  sz;
      logic [31:0] addr;
      int          n;
      for (int i = 0; i < 65536; i++) begin
         v = (i < 256) ? $urandom : 32'h0;
         mem[i]     = v;
         ref_mem[i] = v;
      end

      repeat (2) @(posedge Clk);
      @(negedge Clk);
      chk("reset_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, MemWrite, Address, WriteData}, RST_VEC);
      Rst = 1'b0;

      issue(1, SZ_WORD, 0, 32'h10, 32'hDEAD_BEEF, 1);
      issue(0, SZ_WORD, 0, 32'h10, 32'h0, 1);
      issue(1, SZ_WORD, 0, 32'h10, 32'h1122_3344, 1);
      issue(1, SZ_BYTE, 0, 32'h13, 32'h0000_00A5, 1);
      issue(0, SZ_BYTE, 1, 32'h13, 32'h0, 1);
      issue(0, SZ_BYTE, 0, 32'h13, 32'h0, 1);
      issue(1, SZ_WORD, 0, 32'h10, 32'h8001_7FFF, 1);
      issue(0, SZ_HALF, 1, 32'h12, 32'h0, 1);
      issue(0, SZ_HALF, 1, 32'h10, 32'h0, 1);
      issue(0, SZ_WORD, 0, 32'h11, 32'h0, 1);
      issue(1, SZ_HALF, 0, 32'h01, 32'hBEEF, 1);
      issue(0, SZ_ILLEGAL, 0, 32'h20, 32'h0, 1);
      issue(0, SZ_WORD, 0, 32'h0004_0000, 32'h0, 1);

      wait_idle();
      hold_cnt = 5;
      issue(0, SZ_WORD, 0, 32'h10, 32'h0, 1);

      for (int t = 0; t < 200; t++) begin
         sz   = ($urandom_range(0, 15) == 0) ? SZ_ILLEGAL : 2'($urandom_range(0, 2));
         addr = $urandom_range(0, 1023);
         if ($urandom_range(0, 3) != 0) begin
            if (sz == SZ_HALF) addr[0] = 1'b0;
            if (sz == SZ_WORD) addr[1:0] = 2'b00;
         end
         if ($urandom_range(0, 15) == 0) addr = addr | (32'd1 << $urandom_range(18, 31));
         issue($urandom_range(0, 1) != 0, sz, $urandom_range(0, 1) != 0, addr, $urandom, 1);
      end

      n = 0;
      while ((expq.size() != 0 || in_resp) && n < 500) begin
         @(negedge Clk);
         n++;
      end
      chk("drain_pending", 128'(expq.size()), 128'(0));

      // Byte store to word 9, reset asserted during its WRITE cycle.
      issue(1, SZ_BYTE, 0, 32'h25, 32'h0000_005A, 0);
      @(negedge Clk);
      @(negedge Clk);
      chk("memwrite_before_rst", MemWrite, 1'b1);
      Rst = 1'b1;
      #1;
      chk("memwrite_gated_by_rst", MemWrite, 1'b0);
      @(negedge Clk);
      chk("abort_outputs", {req_ready, rsp_valid, rsp_err, rsp_rdata, MemWrite, Address, WriteData}, RST_VEC);
      chk("abort_mem_unchanged", mem[9], ref_mem[9]);
      Rst = 1'b0;
      repeat (4) @(negedge Clk);
      chk("no_rsp_after_abort", rsp_valid, 1'b0);

      finish_run();
   end

endmodule
